// File: rtl/pe_pkg.sv
// pe_pkg: shared mode encoding and fixed-point helpers for the vector PE.
package pe_pkg;
   typedef enum logic [2:0] {
      PE_MAC = 3'd0,
      PE_EWM = 3'd1,
      PE_EWA = 3'd2,
      PE_EWS = 3'd3,
      PE_ACC = 3'd4
   } pe_mode_e;
   // Helpers work on a common wide signed type; callers size-cast in and slice out.
   localparam int MAXW = 128;
   typedef struct packed {
      logic signed [MAXW-1:0] val;
      logic                   ovf;
   } sat_t;
   function automatic logic signed [MAXW-1:0] rnd_shift(input logic signed [MAXW-1:0] x, input int f, input logic rnd);
      logic signed [MAXW-1:0] h;
      h = (rnd && f > 0) ? (MAXW'(1) <<< (f - 1)) : '0;
      return (x + h) >>> f;
   endfunction
   function automatic sat_t sat_trunc(input logic signed [MAXW-1:0] x, input int dw, input logic sat);
      logic signed [MAXW-1:0] hi, lo;
      sat_t r;
      hi = (MAXW'(1) <<< (dw - 1)) - MAXW'(1);
      lo = ~hi;
      r.ovf = x > hi || x < lo;
      r.val = sat ? (x > hi ? hi : x < lo ? lo : x) : x;
      return r;
   endfunction
endpackage

// File: rtl/pe_lane.sv
// pe_lane: one lane's product stage, add/round/saturate stage and dot-product accumulator.
module pe_lane
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_WIDTH  = 40,
   parameter int SATURATE   = 1,
   parameter int ROUND      = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         v,
   input  logic [2:0]                   mode,
   input  logic                         last,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic signed [DATA_WIDTH-1:0] c,
   output logic [DATA_WIDTH-1:0]        q,
   output logic                         sat
);
   logic signed [2*DATA_WIDTH-1:0] p1;
   logic signed [DATA_WIDTH-1:0]   a1, b1, c1;
   logic signed [ACC_WIDTH-1:0]    acc;
   logic signed [MAXW-1:0]         pw, acc_sum, wide;
   sat_t                           r, ra;
   always_ff @(posedge clk) begin
      if (en) begin
         p1 <= a * b;
         a1 <= a;
         b1 <= b;
         c1 <= c;
      end
   end
   always_comb begin
      pw      = MAXW'(p1);
      acc_sum = MAXW'(acc) + pw;
      wide    = mode == PE_MAC ? rnd_shift(pw, FRAC_BITS, ROUND != 0) + MAXW'(c1) :
                mode == PE_EWM ? rnd_shift(pw, FRAC_BITS, ROUND != 0) :
                mode == PE_EWA ? MAXW'(a1) + MAXW'(b1) :
                mode == PE_EWS ? MAXW'(a1) - MAXW'(b1) :
                mode == PE_ACC ? rnd_shift(acc_sum, FRAC_BITS, ROUND != 0) : '0;
      r       = sat_trunc(wide, DATA_WIDTH, SATURATE != 0);
      ra      = sat_trunc(acc_sum, ACC_WIDTH, 1'b1);
   end
   // Non-last ACC beats also load q/sat, but out_valid stays low for them.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         q   <= '0;
         sat <= 1'b0;
      end else if (en && v) begin
         q   <= r.val[DATA_WIDTH-1:0];
         sat <= r.ovf;
         if (mode == PE_ACC) acc <= last ? '0 : ra.val[ACC_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/pe_vec_unit.sv
// pe_vec_unit: LANES-wide two-stage fixed-point MAC/EWM/EWA/EWS/ACC unit with valid/ready flow control.
module pe_vec_unit
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int LANES      = 4,
   parameter int ACC_WIDTH  = 40,
   parameter int SATURATE   = 1,
   parameter int ROUND      = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_mode,
   input  logic                          in_last,
   input  logic [LANES*DATA_WIDTH-1:0]   in_a,
   input  logic [LANES*DATA_WIDTH-1:0]   in_b,
   input  logic [LANES*DATA_WIDTH-1:0]   in_c,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*DATA_WIDTH-1:0]   out_data,
   output logic [LANES-1:0]              out_sat
);
   logic       adv, v1, last1;
   logic [2:0] mode1;
   assign adv      = !(out_valid && !out_ready);
   assign in_ready = adv;
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         v1        <= in_valid;
         out_valid <= v1 && !(mode1 == PE_ACC && !last1);
      end
   end
   always_ff @(posedge clk) begin
      if (adv) begin
         mode1 <= in_mode;
         last1 <= in_last;
      end
   end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      pe_lane #(
         .DATA_WIDTH(DATA_WIDTH),
         .FRAC_BITS (FRAC_BITS),
         .ACC_WIDTH (ACC_WIDTH),
         .SATURATE  (SATURATE),
         .ROUND     (ROUND)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .en  (adv),
         .v   (v1),
         .mode(mode1),
         .last(last1),
         .a   (in_a[i*DATA_WIDTH +: DATA_WIDTH]),
         .b   (in_b[i*DATA_WIDTH +: DATA_WIDTH]),
         .c   (in_c[i*DATA_WIDTH +: DATA_WIDTH]),
         .q   (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .sat (out_sat[i])
      );
   end
endmodule
